// File: rtl/operand_fetch_if.sv
// ID/EX boundary bundle for operand_fetch: the ID slot, register-file ports,
// write-back bypass inputs, flush/stall control and the registered EX fields.
interface operand_fetch_if;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_flush;
  logic        stall_id;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_instr;
  logic [31:0] ex_op1;
  logic [31:0] ex_op2;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rd;
  logic        ex_is_load;
  logic [31:0] stall_count;

  modport slave (
    input  id_valid, id_pc, id_instr, rs1_data, rs2_data,
           wb_we, wb_rd, wb_data, ex_flush,
    output rs1_addr, rs2_addr, stall_id, ex_valid, ex_pc, ex_instr,
           ex_op1, ex_op2, ex_imm, ex_rd, ex_is_load, stall_count
  );

  modport master (
    output id_valid, id_pc, id_instr, rs1_data, rs2_data,
           wb_we, wb_rd, wb_data, ex_flush,
    input  rs1_addr, rs2_addr, stall_id, ex_valid, ex_pc, ex_instr,
           ex_op1, ex_op2, ex_imm, ex_rd, ex_is_load, stall_count
  );
endinterface

// File: rtl/operand_fetch.sv
// Decode-to-execute stage: RF address drive, write-back bypass, immediate decode,
// load-use hazard detection and the ID/EX pipeline register.
module operand_fetch #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic           clk,
  input  logic           rst_n,
  operand_fetch_if.slave io_of
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  logic [31:0]     w_instr;
  logic [6:0]      w_opcode;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [4:0]      w_rd;
  logic            w_uses_rs1;
  logic            w_uses_rs2;
  logic            w_has_rd;
  logic            w_hazard;
  logic            w_stall;
  logic [XLEN-1:0] w_op1;
  logic [XLEN-1:0] w_op2;
  logic [XLEN-1:0] w_imm;

  logic            r_ex_valid;
  logic [XLEN-1:0] r_ex_pc;
  logic [31:0]     r_ex_instr;
  logic [XLEN-1:0] r_ex_op1;
  logic [XLEN-1:0] r_ex_op2;
  logic [XLEN-1:0] r_ex_imm;
  logic [4:0]      r_ex_rd;
  logic            r_ex_is_load;
  logic [31:0]     r_stall_count;

  assign w_instr  = io_of.id_instr;
  assign w_opcode = w_instr[6:0];
  assign w_rd     = w_instr[11:7];
  assign w_rs1    = w_instr[19:15];
  assign w_rs2    = w_instr[24:20];

  assign w_uses_rs1 = (w_opcode != OP_LUI) && (w_opcode != OP_AUIPC) && (w_opcode != OP_JAL);
  assign w_uses_rs2 = (w_opcode == OP_REG) || (w_opcode == OP_STORE) || (w_opcode == OP_BRANCH);
  assign w_has_rd   = (w_opcode != OP_STORE) && (w_opcode != OP_BRANCH);

  // A same-cycle RF write is not visible on the read port, so forward it here.
  always_comb begin
    w_op1 = io_of.rs1_data;
    if (w_rs1 == 5'd0)
      w_op1 = '0;
    else if (io_of.wb_we && (io_of.wb_rd == w_rs1))
      w_op1 = io_of.wb_data;
  end

  always_comb begin
    w_op2 = io_of.rs2_data;
    if (w_rs2 == 5'd0)
      w_op2 = '0;
    else if (io_of.wb_we && (io_of.wb_rd == w_rs2))
      w_op2 = io_of.wb_data;
  end

  always_comb begin
    w_imm = '0;
    case (w_opcode)
      OP_IMM, OP_LOAD, OP_JALR:
        w_imm = {{20{w_instr[31]}}, w_instr[31:20]};
      OP_STORE:
        w_imm = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
      OP_BRANCH:
        w_imm = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25],
                 w_instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        w_imm = {w_instr[31:12], 12'h000};
      OP_JAL:
        w_imm = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20],
                 w_instr[30:21], 1'b0};
      default:
        w_imm = '0;
    endcase
  end

  assign w_hazard = io_of.id_valid && r_ex_valid && r_ex_is_load && (r_ex_rd != 5'd0) &&
                    ((w_uses_rs1 && (r_ex_rd == w_rs1)) || (w_uses_rs2 && (r_ex_rd == w_rs2)));
  assign w_stall  = w_hazard && !io_of.ex_flush;

  // Flush, stall and an empty ID slot all load the same bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid   <= 1'b0;
      r_ex_pc      <= '0;
      r_ex_instr   <= NOP_INSTR;
      r_ex_op1     <= '0;
      r_ex_op2     <= '0;
      r_ex_imm     <= '0;
      r_ex_rd      <= 5'd0;
      r_ex_is_load <= 1'b0;
    end else if (io_of.ex_flush || w_hazard || !io_of.id_valid) begin
      r_ex_valid   <= 1'b0;
      r_ex_pc      <= '0;
      r_ex_instr   <= NOP_INSTR;
      r_ex_op1     <= '0;
      r_ex_op2     <= '0;
      r_ex_imm     <= '0;
      r_ex_rd      <= 5'd0;
      r_ex_is_load <= 1'b0;
    end else begin
      r_ex_valid   <= 1'b1;
      r_ex_pc      <= io_of.id_pc;
      r_ex_instr   <= w_instr;
      r_ex_op1     <= w_op1;
      r_ex_op2     <= w_op2;
      r_ex_imm     <= w_imm;
      r_ex_rd      <= w_has_rd ? w_rd : 5'd0;
      r_ex_is_load <= (w_opcode == OP_LOAD);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_stall_count <= '0;
    else if (w_stall && (r_stall_count != 32'hFFFF_FFFF))
      r_stall_count <= r_stall_count + 32'd1;
  end

  assign io_of.rs1_addr    = w_rs1;
  assign io_of.rs2_addr    = w_rs2;
  assign io_of.stall_id    = w_stall;
  assign io_of.ex_valid    = r_ex_valid;
  assign io_of.ex_pc       = r_ex_pc;
  assign io_of.ex_instr    = r_ex_instr;
  assign io_of.ex_op1      = r_ex_op1;
  assign io_of.ex_op2      = r_ex_op2;
  assign io_of.ex_imm      = r_ex_imm;
  assign io_of.ex_rd       = r_ex_rd;
  assign io_of.ex_is_load  = r_ex_is_load;
  assign io_of.stall_count = r_stall_count;
endmodule

// File: tb/tb_operand_fetch.sv
// Directed-vector bench for operand_fetch with hand-computed expectations.
module tb_operand_fetch;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fails;

  operand_fetch_if of_if ();

  operand_fetch dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io_of (of_if.slave)
  );

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [31:0] ADDI_X5_7 = 32'h0070_0293;
  localparam logic [31:0] ADD_4_3_3 = 32'h0031_8233;
  localparam logic [31:0] ADD_4_0_0 = 32'h0000_0233;
  localparam logic [31:0] LW_6_0_1  = 32'h0000_A303;
  localparam logic [31:0] ADD_7_6_2 = 32'h0023_03B3;
  localparam logic [31:0] LUI_6_30  = 32'h0003_0337;
  localparam logic [31:0] BEQ_M4    = 32'hFE00_0EE3;
  localparam logic [31:0] JAL_2048  = 32'h0010_00EF;
  localparam logic [31:0] SW_M1     = 32'hFE20_AFA3;
  localparam logic [31:0] LUI_ABCDE = 32'hABCD_E337;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic valid, input logic [31:0] instr, input logic [31:0] pc);
    @(negedge clk);
    of_if.id_valid = valid;
    of_if.id_instr = instr;
    of_if.id_pc    = pc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst_n = 1'b0;
    of_if.id_valid = 1'b1;
    of_if.id_instr = LW_6_0_1;
    of_if.id_pc    = 32'h0000_1234;
    of_if.rs1_data = 32'hDEAD_BEEF;
    of_if.rs2_data = 32'hCAFE_F00D;
    of_if.wb_we    = 1'b0;
    of_if.wb_rd    = 5'd0;
    of_if.wb_data  = 32'h0;
    of_if.ex_flush = 1'b0;

    repeat (3) step();
    check("rst_ex_valid", {31'd0, of_if.ex_valid}, 32'd0);
    check("rst_ex_instr", of_if.ex_instr, NOP);
    check("rst_stall_count", of_if.stall_count, 32'd0);
    check("rst_stall_id", {31'd0, of_if.stall_id}, 32'd0);

    drive(1'b1, ADDI_X5_7, 32'h0000_0100);
    rst_n = 1'b1;
    step();
    check("addi_valid", {31'd0, of_if.ex_valid}, 32'd1);
    check("addi_rd", {27'd0, of_if.ex_rd}, 32'd5);
    check("addi_imm", of_if.ex_imm, 32'd7);
    check("addi_pc", of_if.ex_pc, 32'h0000_0100);
    check("addi_op1_x0", of_if.ex_op1, 32'd0);

    drive(1'b1, ADD_4_3_3, 32'h0000_0104);
    of_if.rs1_data = 32'h11;
    of_if.rs2_data = 32'h11;
    of_if.wb_we    = 1'b1;
    of_if.wb_rd    = 5'd3;
    of_if.wb_data  = 32'hAB;
    #1;
    check("rs1_addr", {27'd0, of_if.rs1_addr}, 32'd3);
    check("rs2_addr", {27'd0, of_if.rs2_addr}, 32'd3);
    step();
    check("byp_op1", of_if.ex_op1, 32'hAB);
    check("byp_op2", of_if.ex_op2, 32'hAB);
    check("byp_rd", {27'd0, of_if.ex_rd}, 32'd4);

    drive(1'b1, ADD_4_3_3, 32'h0000_0108);
    of_if.wb_rd = 5'd5;
    step();
    check("nobyp_op1", of_if.ex_op1, 32'h11);
    check("nobyp_op2", of_if.ex_op2, 32'h11);

    drive(1'b1, ADD_4_0_0, 32'h0000_010C);
    of_if.wb_rd = 5'd0;
    step();
    check("x0_op1", of_if.ex_op1, 32'd0);
    check("x0_op2", of_if.ex_op2, 32'd0);

    drive(1'b1, LW_6_0_1, 32'h0000_0110);
    of_if.wb_we = 1'b0;
    step();
    check("lw_is_load", {31'd0, of_if.ex_is_load}, 32'd1);
    check("lw_rd", {27'd0, of_if.ex_rd}, 32'd6);
    drive(1'b1, ADD_7_6_2, 32'h0000_0114);
    of_if.rs1_data = 32'h66;
    of_if.rs2_data = 32'h22;
    #1;
    check("lu_stall", {31'd0, of_if.stall_id}, 32'd1);
    step();
    check("lu_bubble_valid", {31'd0, of_if.ex_valid}, 32'd0);
    check("lu_bubble_instr", of_if.ex_instr, NOP);
    check("lu_stall_count", of_if.stall_count, 32'd1);
    check("lu_stall_clear", {31'd0, of_if.stall_id}, 32'd0);
    step();
    check("lu_add_valid", {31'd0, of_if.ex_valid}, 32'd1);
    check("lu_add_instr", of_if.ex_instr, ADD_7_6_2);
    check("lu_add_rd", {27'd0, of_if.ex_rd}, 32'd7);
    check("lu_add_op1", of_if.ex_op1, 32'h66);
    check("lu_add_op2", of_if.ex_op2, 32'h22);

    drive(1'b1, LW_6_0_1, 32'h0000_0118);
    step();
    drive(1'b1, LUI_6_30, 32'h0000_011C);
    #1;
    check("lui_no_stall", {31'd0, of_if.stall_id}, 32'd0);
    step();
    check("lui_instr", of_if.ex_instr, LUI_6_30);
    check("lui_imm", of_if.ex_imm, 32'h0003_0000);
    check("lui_count", of_if.stall_count, 32'd1);

    drive(1'b1, LW_6_0_1, 32'h0000_0120);
    step();
    drive(1'b1, ADD_7_6_2, 32'h0000_0124);
    of_if.ex_flush = 1'b1;
    #1;
    check("flush_stall_id", {31'd0, of_if.stall_id}, 32'd0);
    step();
    check("flush_valid", {31'd0, of_if.ex_valid}, 32'd0);
    check("flush_instr", of_if.ex_instr, NOP);
    check("flush_count", of_if.stall_count, 32'd1);

    drive(1'b1, BEQ_M4, 32'h0000_0200);
    of_if.ex_flush = 1'b0;
    step();
    check("beq_imm", of_if.ex_imm, 32'hFFFF_FFFC);
    check("beq_rd", {27'd0, of_if.ex_rd}, 32'd0);
    drive(1'b1, JAL_2048, 32'h0000_0204);
    step();
    check("jal_imm", of_if.ex_imm, 32'h0000_0800);
    check("jal_rd", {27'd0, of_if.ex_rd}, 32'd1);
    drive(1'b1, SW_M1, 32'h0000_0208);
    step();
    check("sw_imm", of_if.ex_imm, 32'hFFFF_FFFF);
    check("sw_rd", {27'd0, of_if.ex_rd}, 32'd0);
    drive(1'b1, LUI_ABCDE, 32'h0000_020C);
    step();
    check("lui2_imm", of_if.ex_imm, 32'hABCD_E000);

    drive(1'b0, ADDI_X5_7, 32'h0000_0210);
    step();
    check("inv_valid", {31'd0, of_if.ex_valid}, 32'd0);
    check("inv_instr", of_if.ex_instr, NOP);
    check("inv_pc", of_if.ex_pc, 32'd0);
    check("inv_imm", of_if.ex_imm, 32'd0);

    drive(1'b1, LW_6_0_1, 32'h0000_0300);
    force dut.r_stall_count = 32'hFFFF_FFFE;
    #1;
    release dut.r_stall_count;
    step();
    check("sat_preload", of_if.stall_count, 32'hFFFF_FFFE);
    drive(1'b1, ADD_7_6_2, 32'h0000_0304);
    step();
    check("sat_reach_max", of_if.stall_count, 32'hFFFF_FFFF);
    step();
    drive(1'b1, LW_6_0_1, 32'h0000_0308);
    step();
    drive(1'b1, ADD_7_6_2, 32'h0000_030C);
    #1;
    check("sat_stall_id", {31'd0, of_if.stall_id}, 32'd1);
    step();
    check("sat_hold", of_if.stall_count, 32'hFFFF_FFFF);
    step();
    check("pre_arst_valid", {31'd0, of_if.ex_valid}, 32'd1);

    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, of_if.ex_valid}, 32'd0);
    check("arst_instr", of_if.ex_instr, NOP);
    check("arst_count", of_if.stall_count, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end
endmodule
